// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: per-channel half-period register,
// enable, registered square-wave output and a tick strobe on every output edge.
module clock_divider_multi #(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned CNT_W       = 18,
   parameter int unsigned DEFAULT_DIV = 100000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] en,
   input  logic              sync,
   input  logic              cfg_we,
   input  logic [3:0]        cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick
);

   localparam int unsigned CH_IDX_W = 4;
   localparam logic [CNT_W-1:0] RESET_DIV = CNT_W'(DEFAULT_DIV);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] div_q;
      logic             out_q;
      logic             tick_q;
      logic             wr_hit_c;
      logic             terminal_c;

      // Out-of-range channel indices never match, so such writes are dropped.
      assign wr_hit_c   = cfg_we && (cfg_ch == CH_IDX_W'(i));
      assign terminal_c = (cnt_q == div_q);

      // Priority: reset, sync, config write, enable gating, counting.
      always_ff @(posedge clk) begin
         if (!reset) begin
            cnt_q  <= '0;
            div_q  <= RESET_DIV;
            out_q  <= 1'b0;
            tick_q <= 1'b0;
         end else begin
            tick_q <= 1'b0;
            if (wr_hit_c) begin
               div_q <= cfg_div;
            end
            if (sync) begin
               cnt_q <= '0;
               out_q <= 1'b0;
            end else if (wr_hit_c) begin
               cnt_q <= '0;
            end else if (en[i]) begin
               if (terminal_c) begin
                  cnt_q  <= '0;
                  out_q  <= ~out_q;
                  tick_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
         end
      end

      assign clk_out[i] = out_q;
      assign tick[i]    = tick_q;
   end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Scoreboard bench for clock_divider_multi: a countdown reference model predicts
// outputs per cycle; a negedge monitor pops and compares, plus spec-level timing checks.
module tb_clock_divider_multi;
   localparam int unsigned NUM_CH      = 4;
   localparam int unsigned CNT_W       = 4;
   localparam int unsigned DEFAULT_DIV = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic [NUM_CH-1:0] en;
   logic              sync;
   logic              cfg_we;
   logic [3:0]        cfg_ch;
   logic [CNT_W-1:0]  cfg_div;
   logic [NUM_CH-1:0] clk_out;
   logic [NUM_CH-1:0] tick;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct packed {
      logic [NUM_CH-1:0] out;
      logic [NUM_CH-1:0] tk;
   } exp_t;
   exp_t sb_q[$];

   // Reference model: cycles remaining until the next toggle, per channel.
   int m_rem  [NUM_CH];
   int m_div  [NUM_CH];
   bit m_out  [NUM_CH];
   bit m_tick [NUM_CH];

   logic [NUM_CH-1:0] cur_en = '1;

   always #5 clk = ~clk;

   clock_divider_multi #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)
   ) dut (
      .clk(clk), .reset(reset), .en(en), .sync(sync), .cfg_we(cfg_we),
      .cfg_ch(cfg_ch), .cfg_div(cfg_div), .clk_out(clk_out), .tick(tick)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_update(input logic r, input logic [NUM_CH-1:0] e, input logic s,
                               input logic we, input logic [3:0] ch, input int d);
      for (int i = 0; i < NUM_CH; i++) begin
         if (!r) begin
            m_div[i] = DEFAULT_DIV; m_rem[i] = DEFAULT_DIV; m_out[i] = 0; m_tick[i] = 0;
         end else begin
            bit wr;
            wr = we && (int'(ch) == i);
            m_tick[i] = 0;
            if (wr) m_div[i] = d;
            if (s) begin
               m_rem[i] = m_div[i]; m_out[i] = 0;
            end else if (wr) begin
               m_rem[i] = m_div[i];
            end else if (e[i]) begin
               if (m_rem[i] == 0) begin
                  m_out[i] = !m_out[i]; m_tick[i] = 1; m_rem[i] = m_div[i];
               end else begin
                  m_rem[i]--;
               end
            end
         end
      end
   endtask

   task automatic step(input logic r, input logic [NUM_CH-1:0] e, input logic s,
                       input logic we, input logic [3:0] ch, input logic [CNT_W-1:0] d);
      exp_t x;
      reset = r; en = e; sync = s; cfg_we = we; cfg_ch = ch; cfg_div = d;
      model_update(r, e, s, we, ch, int'(d));
      for (int i = 0; i < NUM_CH; i++) begin
         x.out[i] = m_out[i];
         x.tk[i]  = m_tick[i];
      end
      @(posedge clk);
      sb_q.push_back(x);
      cyc++;
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b1, cur_en, 1'b0, 1'b0, 4'd0, '0);
   endtask

   task automatic wr(input int ch, input int d);
      step(1'b1, cur_en, 1'b0, 1'b1, 4'(ch), CNT_W'(d));
   endtask

   // Cycles from one rising edge of clk_out[ch] to the next.
   task automatic check_period(input int ch, input int exp);
      bit prev, done;
      int t_rise;
      prev = clk_out[ch]; done = 0; t_rise = -1;
      for (int k = 0; k < 200 && !done; k++) begin
         idle(1);
         if (clk_out[ch] && !prev) begin
            if (t_rise < 0) t_rise = k;
            else begin
               check($sformatf("period_ch%0d", ch), k - t_rise, exp);
               done = 1;
            end
         end
         prev = clk_out[ch];
      end
      if (!done) check($sformatf("period_timeout_ch%0d", ch), 0, 1);
   endtask

   // Cycles until tick[ch] next pulses (0 means none within the bound).
   task automatic cycles_to_tick(input int ch, output int n);
      n = 0;
      for (int k = 1; k <= 100 && n == 0; k++) begin
         idle(1);
         if (tick[ch]) n = k;
      end
   endtask

   // Scoreboard monitor.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (clk_out !== e.out || tick !== e.tk) begin
               errors++;
               $display("FAIL scoreboard cycle %0d: got out=%b tick=%b expected out=%b tick=%b",
                        cyc, clk_out, tick, e.out, e.tk);
            end
         end
      end
   end

   initial begin
      int n;
      int first[NUM_CH];
      int exp_first[NUM_CH];
      bit held;
      exp_first = '{1, 2, 5, 10};

      // Reset default behaviour.
      for (int k = 0; k < 3; k++) step(1'b0, '1, 1'b0, 1'b0, 4'd0, '0);
      check("reset_out", int'(clk_out), 0);
      check("reset_tick", int'(tick), 0);
      cycles_to_tick(0, n);
      check("first_tick_after_reset", n, 4);
      check_period(0, 8);

      // Per-channel configuration, then phase-align.
      wr(0, 0); wr(1, 1); wr(2, 4); wr(3, 9);
      step(1'b1, cur_en, 1'b1, 1'b0, 4'd0, '0);
      first = '{-1, -1, -1, -1};
      for (int k = 1; k <= 12; k++) begin
         idle(1);
         for (int c = 0; c < NUM_CH; c++) if (first[c] < 0 && clk_out[c]) first[c] = k;
      end
      for (int c = 0; c < NUM_CH; c++) check($sformatf("first_rise_ch%0d", c), first[c], exp_first[c]);
      check_period(0, 2); check_period(1, 4); check_period(2, 10); check_period(3, 20);

      // Enable gating on channel 1.
      wr(1, 4); idle(2);
      held = clk_out[1];
      cur_en[1] = 1'b0;
      for (int k = 0; k < 7; k++) begin
         idle(1);
         check("gated_tick1", int'(tick[1]), 0);
      end
      check("gated_hold1", int'(clk_out[1]), int'(held));
      cur_en[1] = 1'b1;
      cycles_to_tick(1, n);
      check("resume_tick1", n, 3);

      // Write colliding with a terminal count.
      step(1'b1, cur_en, 1'b1, 1'b0, 4'd0, '0);
      wr(2, 5); idle(5);
      held = clk_out[2];
      wr(2, 2);
      check("collision_tick2", int'(tick[2]), 0);
      check("collision_hold2", int'(clk_out[2]), int'(held));
      cycles_to_tick(2, n);
      check("after_collision_tick2", n, 3);
      wr(7, 1); idle(4);

      // sync coincident with a write.
      step(1'b1, cur_en, 1'b1, 1'b1, 4'd0, CNT_W'(6));
      check("sync_wr_out0", int'(clk_out[0]), 0);
      cycles_to_tick(0, n);
      check("sync_wr_tick0", n, 7);

      // Mid-operation reset restores the default divisor.
      idle(3);
      step(1'b0, cur_en, 1'b0, 1'b0, 4'd0, '0);
      check_period(1, 8); check_period(3, 8);

      // Full-range counter.
      wr(3, 15);
      cycles_to_tick(3, n);
      check("wide_first_tick", n, 16);
      cycles_to_tick(3, n);
      check("wide_tick_interval", n, 16);
      check_period(3, 32);

      // Randomized traffic against the model.
      for (int k = 0; k < 1500; k++) begin
         logic r, s, w;
         r = ($urandom_range(0, 63) != 0);
         s = ($urandom_range(0, 15) == 0);
         w = ($urandom_range(0, 7) == 0);
         step(r, NUM_CH'($urandom), s, w, 4'($urandom_range(0, 7)), CNT_W'($urandom));
      end

      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
